// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter at the completion end of the execute stage.
// Each functional unit owns a one-entry result slot. Every cycle the valid slot
// whose ROB index is oldest relative to rob_head is granted and registered onto
// the single writeback bus. Results squashed by a mispredict flush are dropped,
// either on entry (squashed handshake) or while they sit in a slot.
module wb_arbiter #(
   parameter int NUM_FU = 8,
   parameter int DATA_W = 32,
   parameter int PREG_W = 7,
   parameter int ROB_W  = 3
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_FU-1:0]           fu_valid,
   output logic [NUM_FU-1:0]           fu_ready,
   input  logic [NUM_FU*DATA_W-1:0]    fu_data,
   input  logic [NUM_FU*PREG_W-1:0]    fu_rd,
   input  logic [NUM_FU*ROB_W-1:0]     fu_rob_idx,
   input  logic [ROB_W-1:0]            rob_head,
   input  logic                        mispredict,
   input  logic [2**ROB_W-1:0]         flush_mask,
   output logic                        wb_valid,
   output logic [DATA_W-1:0]           wb_data,
   output logic [PREG_W-1:0]           wb_rd,
   output logic [ROB_W-1:0]            wb_rob_idx,
   output logic [$clog2(NUM_FU)-1:0]   wb_fu
);

   localparam int FU_W = $clog2(NUM_FU);

   // Per-unit views of the flattened input buses
   logic [DATA_W-1:0]  in_data   [NUM_FU];
   logic [PREG_W-1:0]  in_rd     [NUM_FU];
   logic [ROB_W-1:0]   in_rob    [NUM_FU];

   // Result slots, one per unit
   logic [NUM_FU-1:0]  slot_valid_reg;
   logic [NUM_FU-1:0]  slot_valid_next;
   logic [DATA_W-1:0]  slot_data_reg   [NUM_FU];
   logic [DATA_W-1:0]  slot_data_next  [NUM_FU];
   logic [PREG_W-1:0]  slot_rd_reg     [NUM_FU];
   logic [PREG_W-1:0]  slot_rd_next    [NUM_FU];
   logic [ROB_W-1:0]   slot_rob_reg    [NUM_FU];
   logic [ROB_W-1:0]   slot_rob_next   [NUM_FU];

   // Arbitration and handshake terms
   logic [ROB_W-1:0]   age [NUM_FU];
   logic [NUM_FU-1:0]  grant;
   logic [NUM_FU-1:0]  accept;
   logic [NUM_FU-1:0]  in_squash;
   logic [NUM_FU-1:0]  slot_flush;

   // Granted-slot mux outputs
   logic               any_grant;
   logic               gnt_flush;
   logic [FU_W-1:0]    gnt_fu;
   logic [DATA_W-1:0]  gnt_data;
   logic [PREG_W-1:0]  gnt_rd;
   logic [ROB_W-1:0]   gnt_rob;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FU; gi++) begin : g_unit
         logic win;

         assign in_data[gi] = fu_data[gi*DATA_W +: DATA_W];
         assign in_rd[gi]   = fu_rd[gi*PREG_W +: PREG_W];
         assign in_rob[gi]  = fu_rob_idx[gi*ROB_W +: ROB_W];

         // Distance from the ROB head; unsigned wrap gives the mod-2**ROB_W age.
         assign age[gi] = slot_rob_reg[gi] - rob_head;

         // A result arriving for a squashed ROB entry is swallowed on entry.
         assign in_squash[gi]  = mispredict && flush_mask[in_rob[gi]];
         // A result already buffered for a squashed ROB entry is dropped.
         assign slot_flush[gi] = mispredict && flush_mask[slot_rob_reg[gi]];

         // This slot wins if no other valid slot is strictly older, or equally old at a lower index.
         always_comb begin
            win = slot_valid_reg[gi];
            for (int j = 0; j < NUM_FU; j++) begin
               if (j != gi && slot_valid_reg[j] &&
                   ((age[j] < age[gi]) || ((age[j] == age[gi]) && (j < gi)))) begin
                  win = 1'b0;
               end
            end
         end

         assign grant[gi]    = win;
         // Ready when the slot is empty or is draining this cycle; independent of fu_valid.
         assign fu_ready[gi] = !slot_valid_reg[gi] || grant[gi];
         assign accept[gi]   = fu_valid[gi] && fu_ready[gi];
      end
   endgenerate

   // Select the fields of the (one-hot) granted slot for the writeback register.
   always_comb begin
      any_grant = |grant;
      gnt_fu    = '0;
      gnt_data  = '0;
      gnt_rd    = '0;
      gnt_rob   = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (grant[i]) begin
            gnt_fu   = FU_W'(i);
            gnt_data = slot_data_reg[i];
            gnt_rd   = slot_rd_reg[i];
            gnt_rob  = slot_rob_reg[i];
         end
      end
      // A granted result flushed at the same edge is discarded; no re-arbitration.
      gnt_flush = mispredict && flush_mask[gnt_rob];
   end

   // Next slot contents: a new handshake reloads, otherwise drain or flush empties the slot.
   always_comb begin
      slot_valid_next = slot_valid_reg;
      slot_data_next  = slot_data_reg;
      slot_rd_next    = slot_rd_reg;
      slot_rob_next   = slot_rob_reg;
      for (int i = 0; i < NUM_FU; i++) begin
         if (accept[i]) begin
            slot_valid_next[i] = !in_squash[i];
            slot_data_next[i]  = in_data[i];
            slot_rd_next[i]    = in_rd[i];
            slot_rob_next[i]   = in_rob[i];
         end else if (grant[i] || slot_flush[i]) begin
            slot_valid_next[i] = 1'b0;
         end
      end
   end

   // Slot storage
   always_ff @(posedge clk) begin
      if (rst) begin
         slot_valid_reg <= '0;
         for (int i = 0; i < NUM_FU; i++) begin
            slot_data_reg[i] <= '0;
            slot_rd_reg[i]   <= '0;
            slot_rob_reg[i]  <= '0;
         end
      end else begin
         slot_valid_reg <= slot_valid_next;
         slot_data_reg  <= slot_data_next;
         slot_rd_reg    <= slot_rd_next;
         slot_rob_reg   <= slot_rob_next;
      end
   end

   // Writeback register: one-cycle pulse per surviving grant; payload held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid   <= 1'b0;
         wb_data    <= '0;
         wb_rd      <= '0;
         wb_rob_idx <= '0;
         wb_fu      <= '0;
      end else begin
         wb_valid <= any_grant && !gnt_flush;
         if (any_grant) begin
            wb_data    <= gnt_data;
            wb_rd      <= gnt_rd;
            wb_rob_idx <= gnt_rob;
            wb_fu      <= gnt_fu;
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus a randomized run against a
// slot-level reference model of the writeback arbiter.
module tb_wb_arbiter;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    fu_valid;
   logic [7:0]    fu_ready;
   logic [255:0]  fu_data;
   logic [55:0]   fu_rd;
   logic [23:0]   fu_rob_idx;
   logic [2:0]    rob_head;
   logic          mispredict;
   logic [7:0]    flush_mask;
   logic          wb_valid;
   logic [31:0]   wb_data;
   logic [6:0]    wb_rd;
   logic [2:0]    wb_rob_idx;
   logic [2:0]    wb_fu;

   int tests_run    = 0;
   int tests_failed = 0;

   wb_arbiter #(.NUM_FU(8), .DATA_W(32), .PREG_W(7), .ROB_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .fu_valid   (fu_valid),
      .fu_ready   (fu_ready),
      .fu_data    (fu_data),
      .fu_rd      (fu_rd),
      .fu_rob_idx (fu_rob_idx),
      .rob_head   (rob_head),
      .mispredict (mispredict),
      .flush_mask (flush_mask),
      .wb_valid   (wb_valid),
      .wb_data    (wb_data),
      .wb_rd      (wb_rd),
      .wb_rob_idx (wb_rob_idx),
      .wb_fu      (wb_fu)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      fu_valid   = '0;
      fu_data    = '0;
      fu_rd      = '0;
      fu_rob_idx = '0;
      mispredict = 1'b0;
      flush_mask = '0;
   endtask

   task automatic drive_unit(input int u, input logic [31:0] d, input logic [6:0] rd, input logic [2:0] rob);
      fu_valid[u]            = 1'b1;
      fu_data[u*32 +: 32]    = d;
      fu_rd[u*7 +: 7]        = rd;
      fu_rob_idx[u*3 +: 3]   = rob;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      rob_head = 3'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_wb_valid got %0b want 0", wb_valid); end
      tests_run++;
      if (fu_ready !== 8'hFF) begin tests_failed++; $display("FAIL reset_fu_ready got %h want ff", fu_ready); end
      tests_run++;
      if ({wb_data, wb_rd, wb_rob_idx, wb_fu} !== '0) begin
         tests_failed++;
         $display("FAIL reset_wb_fields got data=%h rd=%0d rob=%0d fu=%0d want all 0", wb_data, wb_rd, wb_rob_idx, wb_fu);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      rob_head = 3'd0;
      drive_unit(0, 32'hDEAD_BEEF, 7'd5, 3'd3);
      @(posedge clk); #1;
      clear_inputs();
      tests_run++;
      if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early got wb_valid=%0b want 0", wb_valid); end
      @(posedge clk); #1;
      $display("[TB] single: wb_valid=%0b data=%h rd=%0d rob=%0d fu=%0d", wb_valid, wb_data, wb_rd, wb_rob_idx, wb_fu);
      tests_run++;
      if ({wb_valid, wb_data, wb_rd, wb_rob_idx, wb_fu} !== {1'b1, 32'hDEAD_BEEF, 7'd5, 3'd3, 3'd0}) begin
         tests_failed++;
         $display("FAIL single_wb got v=%0b data=%h rd=%0d rob=%0d fu=%0d want v=1 data=deadbeef rd=5 rob=3 fu=0",
                  wb_valid, wb_data, wb_rd, wb_rob_idx, wb_fu);
      end
      @(posedge clk); #1;
      tests_run++;
      if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL single_pulse got wb_valid=%0b want 0", wb_valid); end
   endtask

   task automatic test_wrap();
      rob_head = 3'd6;
      drive_unit(1, 32'h1111_0001, 7'd11, 3'd0);
      drive_unit(4, 32'h4444_0007, 7'd12, 3'd7);
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      tests_run++;
      if (fu_ready !== 8'b1111_1101) begin tests_failed++; $display("FAIL wrap_ready got %b want 11111101", fu_ready); end
      @(posedge clk); #1;
      $display("[TB] wrap: wb_valid=%0b rob=%0d fu=%0d", wb_valid, wb_rob_idx, wb_fu);
      tests_run++;
      if ({wb_valid, wb_rob_idx, wb_fu, wb_data} !== {1'b1, 3'd7, 3'd4, 32'h4444_0007}) begin
         tests_failed++;
         $display("FAIL wrap_first got v=%0b rob=%0d fu=%0d data=%h want v=1 rob=7 fu=4 data=44440007",
                  wb_valid, wb_rob_idx, wb_fu, wb_data);
      end
      @(posedge clk); #1;
      $display("[TB] wrap: wb_valid=%0b rob=%0d fu=%0d", wb_valid, wb_rob_idx, wb_fu);
      tests_run++;
      if ({wb_valid, wb_rob_idx, wb_fu, wb_rd} !== {1'b1, 3'd0, 3'd1, 7'd11}) begin
         tests_failed++;
         $display("FAIL wrap_second got v=%0b rob=%0d fu=%0d rd=%0d want v=1 rob=0 fu=1 rd=11",
                  wb_valid, wb_rob_idx, wb_fu, wb_rd);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      rob_head = 3'd0;
      for (int k = 0; k <= 5; k++) begin
         clear_inputs();
         if (k < 4) drive_unit(0, 32'hB000_0000 + 32'(k), 7'(k + 20), 3'(k));
         @(negedge clk);
         if (k < 4) begin
            tests_run++;
            if (fu_ready[0] !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready k=%0d got %0b want 1", k, fu_ready[0]); end
         end
         @(posedge clk); #1;
         if (k >= 1 && k <= 4) begin
            $display("[TB] b2b: wb_valid=%0b rob=%0d data=%h", wb_valid, wb_rob_idx, wb_data);
            tests_run++;
            if ({wb_valid, wb_rob_idx, wb_data} !== {1'b1, 3'(k - 1), 32'hB000_0000 + 32'(k - 1)}) begin
               tests_failed++;
               $display("FAIL b2b_wb k=%0d got v=%0b rob=%0d data=%h want v=1 rob=%0d", k, wb_valid, wb_rob_idx, wb_data, k - 1);
            end
         end else if (k == 5) begin
            tests_run++;
            if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_end got wb_valid=%0b want 0", wb_valid); end
         end
      end
   endtask

   task automatic test_flush();
      rob_head = 3'd0;
      clear_inputs();
      drive_unit(2, 32'h2222_0002, 7'd30, 3'd2);
      drive_unit(6, 32'h6666_0005, 7'd31, 3'd5);
      @(posedge clk); #1;
      clear_inputs();
      mispredict = 1'b1;
      flush_mask = 8'b0010_0000;
      @(posedge clk); #1;
      clear_inputs();
      $display("[TB] flush: wb_valid=%0b rob=%0d fu=%0d", wb_valid, wb_rob_idx, wb_fu);
      tests_run++;
      if ({wb_valid, wb_rob_idx, wb_fu} !== {1'b1, 3'd2, 3'd2}) begin
         tests_failed++;
         $display("FAIL flush_survivor got v=%0b rob=%0d fu=%0d want v=1 rob=2 fu=2", wb_valid, wb_rob_idx, wb_fu);
      end
      @(negedge clk);
      tests_run++;
      if (fu_ready !== 8'hFF) begin tests_failed++; $display("FAIL flush_ready got %b want 11111111", fu_ready); end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         tests_run++;
         if (wb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_dropped cycle=%0d got wb_valid=%0b rob=%0d want 0", k, wb_valid, wb_rob_idx);
         end
      end
   endtask

   task automatic test_squash_accept();
      rob_head = 3'd0;
      clear_inputs();
      drive_unit(3, 32'h3333_0004, 7'd40, 3'd4);
      mispredict = 1'b1;
      flush_mask = 8'b0001_0000;
      @(negedge clk);
      tests_run++;
      if (fu_ready[3] !== 1'b1) begin tests_failed++; $display("FAIL squash_handshake got fu_ready[3]=%0b want 1", fu_ready[3]); end
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      tests_run++;
      if (fu_ready !== 8'hFF) begin tests_failed++; $display("FAIL squash_slot_empty got fu_ready=%b want 11111111", fu_ready); end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         tests_run++;
         if (wb_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL squash_no_wb cycle=%0d got wb_valid=%0b rob=%0d want 0", k, wb_valid, wb_rob_idx);
         end
      end
   endtask

   // Randomized traffic. The model keeps one buffered result per unit and, each
   // cycle, writes back the buffered result nearest to rob_head (mod 8).
   task automatic test_random(input int n);
      bit          m_valid [8];
      logic [2:0]  m_rob   [8];
      logic [31:0] m_data  [8];
      logic [6:0]  m_rd    [8];
      bit          p_valid [8];
      logic [2:0]  p_rob   [8];
      logic [31:0] p_data  [8];
      logic [6:0]  p_rd    [8];
      bit          in_use  [8];
      int          free_list [$];
      int          g, best, a;
      logic [7:0]  exp_ready;
      bit          exp_wb;
      logic [31:0] e_data;
      logic [6:0]  e_rd;
      logic [2:0]  e_rob;
      logic [2:0]  e_fu;
      bit          misp;
      logic [7:0]  mask;

      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 0; p_valid[i] = 0; in_use[i] = 0;
         m_rob[i] = '0; m_data[i] = '0; m_rd[i] = '0;
         p_rob[i] = '0; p_data[i] = '0; p_rd[i] = '0;
      end
      e_data = '0; e_rd = '0; e_rob = '0; e_fu = '0;

      for (int cyc = 0; cyc < n + 24; cyc++) begin
         // New results appear only from idle units and only for unused ROB entries.
         if (cyc < n) begin
            for (int i = 0; i < 8; i++) begin
               if (!p_valid[i] && $urandom_range(0, 2) != 0) begin
                  free_list.delete();
                  for (int r = 0; r < 8; r++) if (!in_use[r]) free_list.push_back(r);
                  if (free_list.size() > 0) begin
                     p_rob[i]  = 3'(free_list[$urandom_range(0, free_list.size() - 1)]);
                     in_use[p_rob[i]] = 1;
                     p_valid[i] = 1;
                     p_data[i]  = $urandom;
                     p_rd[i]    = 7'($urandom_range(0, 127));
                  end
               end
            end
         end
         misp = (cyc < n) && ($urandom_range(0, 7) == 0);
         mask = misp ? 8'($urandom) : 8'h00;

         clear_inputs();
         for (int i = 0; i < 8; i++) if (p_valid[i]) drive_unit(i, p_data[i], p_rd[i], p_rob[i]);
         mispredict = misp;
         flush_mask = mask;
         rob_head   = 3'($urandom_range(0, 7));

         // Oldest buffered result; strict '<' keeps the lowest unit on equal age.
         g = -1;
         best = 99;
         for (int i = 0; i < 8; i++) begin
            if (m_valid[i]) begin
               a = (int'(m_rob[i]) - int'(rob_head) + 8) % 8;
               if (a < best) begin best = a; g = i; end
            end
         end
         for (int i = 0; i < 8; i++) exp_ready[i] = !m_valid[i] || (g == i);

         @(negedge clk);
         tests_run++;
         if (fu_ready !== exp_ready) begin
            tests_failed++;
            $display("FAIL rand_ready cyc=%0d got %b want %b", cyc, fu_ready, exp_ready);
         end

         exp_wb = 0;
         if (g >= 0) begin
            exp_wb = !(misp && mask[m_rob[g]]);
            e_data = m_data[g];
            e_rd   = m_rd[g];
            e_rob  = m_rob[g];
            e_fu   = 3'(g);
            in_use[m_rob[g]] = 0;
            m_valid[g] = 0;
         end
         for (int i = 0; i < 8; i++) begin
            if (m_valid[i] && misp && mask[m_rob[i]]) begin
               m_valid[i] = 0;
               in_use[m_rob[i]] = 0;
            end
         end
         for (int i = 0; i < 8; i++) begin
            if (p_valid[i] && exp_ready[i]) begin
               p_valid[i] = 0;
               if (misp && mask[p_rob[i]]) begin
                  in_use[p_rob[i]] = 0;
               end else begin
                  m_valid[i] = 1;
                  m_rob[i]   = p_rob[i];
                  m_data[i]  = p_data[i];
                  m_rd[i]    = p_rd[i];
               end
            end
         end

         @(posedge clk); #1;
         tests_run++;
         if (wb_valid !== exp_wb) begin
            tests_failed++;
            $display("FAIL rand_wb_valid cyc=%0d got %0b want %0b", cyc, wb_valid, exp_wb);
         end else if (exp_wb) begin
            $display("[TB] rand cyc=%0d wb rob=%0d fu=%0d rd=%0d data=%h", cyc, wb_rob_idx, wb_fu, wb_rd, wb_data);
            tests_run++;
            if ({wb_data, wb_rd, wb_rob_idx, wb_fu} !== {e_data, e_rd, e_rob, e_fu}) begin
               tests_failed++;
               $display("FAIL rand_wb_fields cyc=%0d got data=%h rd=%0d rob=%0d fu=%0d want data=%h rd=%0d rob=%0d fu=%0d",
                        cyc, wb_data, wb_rd, wb_rob_idx, wb_fu, e_data, e_rd, e_rob, e_fu);
            end
         end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_back_to_back();
      test_flush();
      test_squash_accept();
      test_random(400);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
